// File: rtl/dp_ram_port_ctrl_if.sv
// Request/response and RAM-port bundle for one port of the dual-ported block RAM.
// The slave modport is the controller's view; the master modport is the view of
// the logic that surrounds it (requester, consumer and the RAM port itself).
interface dp_ram_port_ctrl_if #(
    parameter int L2WIDTH = 3,
    parameter int L2SIZE  = 14
);
    localparam int AW = L2SIZE - L2WIDTH;
    localparam int DW = 8 << L2WIDTH;
    localparam int BW = 1 << L2WIDTH;

    logic          init_done;
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [BW-1:0] req_bwe;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wr_data;
    logic [DW-1:0] ram_rd_data;
    logic          ram_enable;
    logic          ram_WE;
    logic [BW-1:0] ram_BWE;

    modport slave (
        output init_done, req_ready, rsp_valid, rsp_rdata,
        output ram_addr, ram_wr_data, ram_enable, ram_WE, ram_BWE,
        input  req_valid, req_wr, req_addr, req_wdata, req_bwe, rsp_ready,
        input  ram_rd_data
    );

    modport master (
        input  init_done, req_ready, rsp_valid, rsp_rdata,
        input  ram_addr, ram_wr_data, ram_enable, ram_WE, ram_BWE,
        output req_valid, req_wr, req_addr, req_wdata, req_bwe, rsp_ready,
        output ram_rd_data
    );
endinterface

// File: rtl/dp_ram_port_ctrl.sv
// One-port front end of the dual-ported block RAM: zero-fills the array after
// reset, then turns valid/ready requests into RAM port cycles. Read data is
// captured into a 2-entry response FIFO so a stalled consumer never loses data.
module dp_ram_port_ctrl #(
    parameter int                       L2WIDTH = 3,
    parameter int                       L2SIZE  = 14,
    parameter logic [(8<<L2WIDTH)-1:0]  FILL    = '0
) (
    input  logic              clk,
    input  logic              reset,
    dp_ram_port_ctrl_if.slave bus
);
    localparam int AW = L2SIZE - L2WIDTH;
    localparam int DW = 8 << L2WIDTH;
    localparam int BW = 1 << L2WIDTH;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state_q;
    logic [AW-1:0] fill_addr_q;
    logic          init_done_q;
    logic          pending_q;      // a read was issued last cycle; its data is on ram_rd_data now
    logic [DW-1:0] buf_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    count_q;

    logic          pop_s;
    logic [2:0]    occ_s;          // buffer occupancy after this cycle, counting the in-flight read
    logic          req_ready_s;
    logic          accept_s;

    // Flow control: reads are only accepted when the FIFO can absorb every in-flight read.
    always_comb begin
        pop_s       = (count_q != 2'd0) && bus.rsp_ready;
        occ_s       = {1'b0, count_q} + {2'b00, pending_q} - {2'b00, pop_s};
        req_ready_s = 1'b0;
        if (reset) begin
            req_ready_s = 1'b0;
        end else if (state_q == ST_RUN) begin
            req_ready_s = bus.req_wr || (occ_s < 3'd2);
        end else begin
            req_ready_s = 1'b0;
        end
        accept_s = bus.req_valid && req_ready_s;
    end

    // RAM port mux: fill sweep during INIT, accepted request during RUN, idle otherwise.
    always_comb begin
        bus.ram_enable  = 1'b0;
        bus.ram_WE      = 1'b0;
        bus.ram_BWE     = {BW{1'b0}};
        bus.ram_addr    = {AW{1'b0}};
        bus.ram_wr_data = {DW{1'b0}};
        if (reset) begin
            bus.ram_enable = 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    bus.ram_enable  = 1'b1;
                    bus.ram_WE      = 1'b1;
                    bus.ram_BWE     = {BW{1'b1}};
                    bus.ram_addr    = fill_addr_q;
                    bus.ram_wr_data = FILL;
                end
                ST_RUN: begin
                    if (accept_s) begin
                        bus.ram_enable  = 1'b1;
                        bus.ram_WE      = bus.req_wr;
                        bus.ram_BWE     = bus.req_wr ? bus.req_bwe : {BW{1'b0}};
                        bus.ram_addr    = bus.req_addr;
                        bus.ram_wr_data = bus.req_wdata;
                    end else begin
                        bus.ram_enable  = 1'b0;
                    end
                end
                default: begin
                    bus.ram_enable = 1'b0;
                end
            endcase
        end
    end

    // Control state: init sweep, read-pending flag and FIFO pointers/count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            fill_addr_q <= {AW{1'b0}};
            init_done_q <= 1'b0;
            pending_q   <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    fill_addr_q <= fill_addr_q + {{(AW-1){1'b0}}, 1'b1};
                    if (fill_addr_q == {AW{1'b1}}) begin
                        state_q     <= ST_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
            pending_q <= accept_s && !bus.req_wr;
            if (pending_q) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, pending_q} - {1'b0, pop_s};
        end
    end

    // Response storage: capture the RAM read data the cycle after the read was issued.
    always_ff @(posedge clk) begin
        if (!reset && pending_q) begin
            buf_q[wr_ptr_q] <= bus.ram_rd_data;
        end
    end

    assign bus.init_done = init_done_q;
    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = (count_q != 2'd0);
    assign bus.rsp_rdata = buf_q[rd_ptr_q];
endmodule

// File: tb/tb_dp_ram_port_ctrl.sv
// Self-checking bench for dp_ram_port_ctrl: behavioural RAM, shadow-memory
// scoreboard of expected read data, and directed init/stream/backpressure/reset cases.
module tb_dp_ram_port_ctrl;
    localparam int          L2WIDTH = 3;
    localparam int          L2SIZE  = 14;
    localparam int          AW      = 11;
    localparam int          DW      = 64;
    localparam int          BW      = 8;
    localparam int          DEPTH   = 2048;
    localparam logic [63:0] FILL    = 64'h0;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [63:0] ram_mem [DEPTH];
    logic [63:0] shadow  [DEPTH];
    logic [63:0] exp_q [$];
    int          pop_cyc_q [$];

    dp_ram_port_ctrl_if #(.L2WIDTH(L2WIDTH), .L2SIZE(L2SIZE)) bus ();

    dp_ram_port_ctrl #(.L2WIDTH(L2WIDTH), .L2SIZE(L2SIZE), .FILL(FILL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural RAM: registered read, byte-masked write; seeded with garbage first.
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < DEPTH; i++) ram_mem[i] <= 64'hDEAD_BEEF_0000_0000 | 64'(i);
        end else if (bus.ram_enable) begin
            if (bus.ram_WE) begin
                for (int b = 0; b < BW; b++)
                    if (bus.ram_BWE[b]) ram_mem[bus.ram_addr][b*8 +: 8] <= bus.ram_wr_data[b*8 +: 8];
            end else begin
                bus.ram_rd_data <= ram_mem[bus.ram_addr];
            end
        end
    end

    // Scoreboard: track accepted requests in a shadow memory and compare responses in order.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            for (int i = 0; i < DEPTH; i++) shadow[i] <= FILL;
        end else begin
            if (bus.req_valid && bus.req_ready) begin
                if (bus.req_wr) begin
                    for (int b = 0; b < BW; b++)
                        if (bus.req_bwe[b]) shadow[bus.req_addr][b*8 +: 8] <= bus.req_wdata[b*8 +: 8];
                end else begin
                    exp_q.push_back(shadow[bus.req_addr]);
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) check_val("rsp_unexpected", 64'd1, 64'd0);
                else check_val("rsp_data", bus.rsp_rdata, exp_q.pop_front());
                pop_cyc_q.push_back(cyc);
            end
        end
    end

    // Present one request from posedge+1 until accepted; returns at posedge+1 after acceptance.
    task automatic send(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic [BW-1:0] bwe, output int stalls, output int acc_cyc);
        bit ok;
        ok = 1'b0;
        stalls = 0;
        acc_cyc = -1;
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = data;
        bus.req_bwe   = bwe;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                ok = 1'b1;
                acc_cyc = cyc;
                break;
            end
            stalls++;
        end
        @(posedge clk);
        #1;
        if (!ok) check_val("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check_val("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_init(output int done_cyc);
        done_cyc = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.init_done) begin
                done_cyc = cyc;
                break;
            end
        end
        check_val("init_done_seen", 64'(done_cyc >= 0), 64'd1);
    endtask

    initial begin
        int st, acc, k, n_wr, bad, first, done_cyc, size0, stall_tot;
        bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0;   bus.req_bwe = '0;  bus.rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_init_done", 64'(bus.init_done), 64'd0);
        check_val("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check_val("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_val("rst_ram_en",    64'(bus.ram_enable), 64'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Init sweep
        n_wr = 0; bad = 0; first = -1; done_cyc = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.init_done) begin
                done_cyc = cyc;
                break;
            end
            if (bus.ram_enable && bus.ram_WE) begin
                if (first < 0) first = cyc;
                if (bus.ram_addr != AW'(n_wr) || bus.ram_wr_data != FILL || bus.ram_BWE != 8'hFF) bad++;
                n_wr++;
            end
        end
        check_val("init_done_seen", 64'(done_cyc >= 0), 64'd1);
        check_val("init_wr_cnt", 64'(n_wr), 64'd2048);
        check_val("init_wr_bad", 64'(bad), 64'd0);
        check_val("init_len", 64'(done_cyc - first), 64'd2048);
        check_val("ready_after_init", 64'(bus.req_ready), 64'd1);
        @(posedge clk); #1;

        // Read of a filled location
        bus.rsp_ready = 1'b1;
        send(1'b0, 11'd5, 64'd0, 8'h00, st, acc); idle();
        drain();

        // Write, partial write, read-back with latency check
        send(1'b1, 11'h10, 64'h1122334455667788, 8'hFF, st, acc);
        check_val("wr_stall", 64'(st), 64'd0);
        send(1'b1, 11'h10, 64'hAAAAAAAAAAAAAAAA, 8'h01, st, acc);
        check_val("wr2_stall", 64'(st), 64'd0);
        send(1'b0, 11'h10, 64'd0, 8'h00, st, acc); idle();
        @(negedge clk);
        check_val("rd_lat_n1", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        check_val("rd_lat_n2", 64'(bus.rsp_valid), 64'd1);
        check_val("wr_merge", bus.rsp_rdata, 64'h11223344556677AA);
        @(posedge clk); #1;
        drain();

        // Streaming reads
        size0 = pop_cyc_q.size(); stall_tot = 0; k = -1;
        for (int a = 0; a < 16; a++) begin
            send(1'b0, AW'(a), 64'd0, 8'h00, st, acc);
            if (a == 0) k = acc;
            stall_tot += st;
        end
        idle();
        drain();
        check_val("stream_stall", 64'(stall_tot), 64'd0);
        check_val("stream_pops", 64'(pop_cyc_q.size() - size0), 64'd16);
        check_val("stream_first", 64'(pop_cyc_q[size0]), 64'(k + 2));
        check_val("stream_last", 64'(pop_cyc_q[size0 + 15]), 64'(k + 17));

        // Backpressure and write while full
        for (int a = 1; a <= 4; a++)
            send(1'b1, AW'(32 + a), 64'hA0A0_0000_0000_0000 | 64'(a), 8'hFF, st, acc);
        bus.rsp_ready = 1'b0;
        size0 = pop_cyc_q.size();
        send(1'b0, 11'd33, 64'd0, 8'h00, st, acc);
        send(1'b0, 11'd34, 64'd0, 8'h00, st, acc);
        check_val("bp_two_stall", 64'(st), 64'd0);
        bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 11'd35;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("bp_ready_lo", 64'(bus.req_ready), 64'd0);
            @(posedge clk); #1;
        end
        check_val("bp_outstanding", 64'(exp_q.size()), 64'd2);
        check_val("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        send(1'b1, 11'h30, 64'hCAFE_F00D_1234_5678, 8'hFF, st, acc);
        check_val("wfull_stall", 64'(st), 64'd0);
        bus.rsp_ready = 1'b1;
        send(1'b0, 11'd35, 64'd0, 8'h00, st, acc);
        check_val("bp_resume_stall", 64'(st), 64'd0);
        send(1'b0, 11'd36, 64'd0, 8'h00, st, acc);
        send(1'b0, 11'h30, 64'd0, 8'h00, st, acc);
        idle();
        drain();
        check_val("bp_pops", 64'(pop_cyc_q.size() - size0), 64'd5);

        // Reset with two responses buffered
        send(1'b1, 11'h40, 64'h5555_6666_7777_8888, 8'hFF, st, acc);
        bus.rsp_ready = 1'b0;
        send(1'b0, 11'd33, 64'd0, 8'h00, st, acc);
        send(1'b0, 11'd34, 64'd0, 8'h00, st, acc);
        idle();
        @(negedge clk);
        check_val("pre_rst_valid", 64'(bus.rsp_valid), 64'd1);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check_val("rst_mid_ram_en", 64'(bus.ram_enable), 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_val("post_rst_valid", 64'(bus.rsp_valid), 64'd0);
        check_val("post_rst_init_done", 64'(bus.init_done), 64'd0);
        check_val("post_rst_ram_en", 64'(bus.ram_enable), 64'd1);
        check_val("post_rst_addr", 64'(bus.ram_addr), 64'd0);
        wait_init(done_cyc);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        send(1'b0, 11'h40, 64'd0, 8'h00, st, acc); idle();
        @(negedge clk);
        @(negedge clk);
        check_val("post_rst_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check_val("post_rst_fill", bus.rsp_rdata, FILL);
        @(posedge clk); #1;
        drain();
        check_val("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dp_ram_port_ctrl.md
# dp_ram_port_ctrl

Request/response front end for one port of the dual-ported block RAM. It zero-fills the RAM after reset, then accepts valid/ready read and write requests and drives the RAM port. Read data returns through a 2-entry response buffer so a stalled consumer never loses data. Two instances, one per RAM port, sit between the cache/DMA logic and the RAM.

## Interface
Parameters:
- L2WIDTH, 3: log2 of the data word width in bytes. Data is 8<<L2WIDTH bits wide; BWE is 1<<L2WIDTH bits wide.
- L2SIZE, 14: log2 of the RAM size in bytes. Word address width AW = L2SIZE-L2WIDTH.
- FILL, 0: word value written to every location during the init sweep.

Ports:
- clk  in  1  clock; one clock domain only.
- reset  in  1  synchronous, active-high reset.
- init_done  out  1  high once the fill sweep is complete.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on a cycle where req_valid && req_ready.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  AW  word address.
- req_wdata  in  8<<L2WIDTH  write data.
- req_bwe  in  1<<L2WIDTH  byte write enables; ignored for reads.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes read data.
- rsp_rdata  out  8<<L2WIDTH  read data, in request order.
- ram_addr  out  AW  RAM port address.
- ram_wr_data  out  8<<L2WIDTH  RAM port write data.
- ram_rd_data  in  8<<L2WIDTH  RAM port read data; registered, valid the cycle after enable.
- ram_enable  out  1  RAM port enable.
- ram_WE  out  1  RAM port write enable.
- ram_BWE  out  1<<L2WIDTH  RAM port byte write enables.

## Operation
- States: INIT and RUN. Reset forces INIT and clears fill_addr, the response buffer and pending.
- INIT, per cycle:
  - Drives ram_enable=1, ram_WE=1, ram_BWE all ones, ram_addr=fill_addr, ram_wr_data=FILL.
  - fill_addr increments by 1.
  - After writing address 2^AW-1, moves to RUN and sets init_done=1.
  - req_ready=0 throughout INIT.
- ram_enable is forced to 0 during any cycle where reset=1.
- RUN: the RAM port is combinationally driven from the request on any cycle where req_valid && req_ready:
  - ram_enable=1, ram_addr=req_addr, ram_WE=req_wr, ram_BWE=req_bwe (all zeros for reads), ram_wr_data=req_wdata.
  - Otherwise ram_enable=0.
- Writes produce no response.
- A read sets pending for the next cycle. While pending=1, ram_rd_data is pushed into the response buffer at the end of that cycle.
- Response buffer: 2-entry FIFO.
  - rsp_valid = (count != 0); rsp_rdata is the head entry.
  - Pop when rsp_valid && rsp_ready.
  - Push and pop on the same cycle are both allowed.
- Flow control: req_ready = RUN && (req_wr || count + pending - pop < 2). The buffer therefore never overflows.
- Writes are accepted regardless of response-buffer state.
- Ordering: a read accepted the cycle after a write to the same address returns the new data. Byte lanes with BWE=0 keep their old value.
- Reset while busy: in-flight reads and buffered responses are discarded, and the init sweep restarts at address 0.

## Timing
- Reset values:
  - init_done=0, req_ready=0, rsp_valid=0, ram_enable=0.
  - rsp_rdata: don't-care while rsp_valid=0.
- Init duration: the first INIT write occurs on the first cycle after reset deasserts. init_done rises exactly 2^AW cycles later (2048 with default parameters), and req_ready can rise on that same cycle.
- Read latency: a read accepted at edge N has its RAM data on ram_rd_data during cycle N+1. The data is pushed at edge N+1, and rsp_valid=1 from cycle N+2.
- Throughput: with rsp_ready=1 held, one read is accepted per cycle indefinitely.
- Backpressure: with rsp_ready=0, at most 2 reads are outstanding. req_ready for reads falls on the cycle after the second read is accepted, and rises on the cycle a pop occurs.
- A write always completes at its acceptance edge.

## Test plan
- Init sweep: release reset and count ram_enable&&ram_WE cycles -> exactly 2048 writes of 0 to addresses 0..2047 in order, then init_done=1 and req_ready=1. A read of address 5 returns 0.
- Write/read: write 0x1122334455667788 to address 0x10 with BWE=0xFF, then write 0xAA.. to address 0x10 with BWE=0x01 the next cycle, then read address 0x10 -> rsp_rdata=0x11223344556677AA, with rsp_valid exactly 2 cycles after the read is accepted.
- Streaming: read addresses 0..15 back-to-back with rsp_ready=1 -> 16 consecutive accepts, responses in order on cycles N+2..N+17.
- Backpressure: rsp_ready=0 while issuing 4 reads -> only 2 are accepted and req_ready=0. Set rsp_ready=1 -> the remaining reads complete, all 4 responses arrive in order, and none are lost or duplicated.
- Write while full: with the buffer full and rsp_ready=0, issue a write -> accepted immediately, and a later read sees the written data.
- Reset mid-stream: assert reset for 1 cycle with 2 responses buffered -> rsp_valid=0, init_done=0, and the sweep restarts at address 0. Previously written data reads back as FILL after init.
